alu_exec_unit: RTL and testbench

// - Execute-stage ALU, XLEN-parametrised: decodes ALUOp/funct3/funct7 into a 5-bit ALU control code and produces the result.
// - Single-cycle RV32I ops complete in 1 cycle. Optional RV32M MUL/DIV/REM runs iteratively over XLEN cycles.
// - busy drives the hazard unit's stall; flush is wired from the branch/hazard unit.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_ctrl_decode.sv | 41 ++++
 rtl/alu_exec_unit.sv | 193 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes, M-extension funct3 values and execute-unit FSM states.
package alu_pkg;

   localparam int ALU_CTRL_W = 5;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 5'b0_0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 5'b0_0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 5'b0_0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 5'b0_0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 5'b0_0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 5'b0_0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 5'b0_0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 5'b0_0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 5'b0_1000;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 5'b0_1001;

   // M-extension codes are {ALU_M_PREFIX, funct3}
   localparam logic [1:0] ALU_M_PREFIX = 2'b10;

   localparam logic [2:0] M_MUL    = 3'b000;
   localparam logic [2:0] M_MULH   = 3'b001;
   localparam logic [2:0] M_MULHSU = 3'b010;
   localparam logic [2:0] M_MULHU  = 3'b011;
   localparam logic [2:0] M_DIV    = 3'b100;
   localparam logic [2:0] M_DIVU   = 3'b101;
   localparam logic [2:0] M_REM    = 3'b110;
   localparam logic [2:0] M_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } alu_state_t;

   function automatic logic is_m_code(input logic [ALU_CTRL_W-1:0] code);
      return code[ALU_CTRL_W-1:ALU_CTRL_W-2] == ALU_M_PREFIX;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp/op5/funct3/funct7 bits into the 5-bit ALU control code.
module alu_ctrl_decode
   import alu_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [1:0]            alu_op,
   input  logic                  op5,
   input  logic [2:0]            funct3,
   input  logic                  funct7_5,
   input  logic                  funct7_0,
   output logic [ALU_CTRL_W-1:0] alu_ctrl
);

   // funct7_5 only selects SUB for R-type; for I-type it is an immediate bit
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         2'b00: alu_ctrl = ALU_ADD;
         2'b01: alu_ctrl = ALU_SUB;
         2'b10: begin
            if (ENABLE_M && op5 && funct7_0) begin
               alu_ctrl = {ALU_M_PREFIX, funct3};
            end else begin
               case (funct3)
                  3'b000:  alu_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                  3'b001:  alu_ctrl = ALU_SLL;
                  3'b010:  alu_ctrl = ALU_SLT;
                  3'b011:  alu_ctrl = ALU_SLTU;
                  3'b100:  alu_ctrl = ALU_XOR;
                  3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                  3'b110:  alu_ctrl = ALU_OR;
                  default: alu_ctrl = ALU_AND;
               endcase
            end
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I ops plus optional iterative RV32M multiply/divide.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic            op5,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            out_valid,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN);

   logic [ALU_CTRL_W-1:0] alu_ctrl;
   logic [SHW-1:0]        shamt;
   logic                  accept;
   logic                  start_m;
   logic [XLEN-1:0]       base_result;

   logic [2:0]            in_f3;
   logic                  a_signed;
   logic                  b_signed;
   logic                  neg_a_in;
   logic                  neg_b_in;
   logic [XLEN-1:0]       abs_a;
   logic [XLEN-1:0]       abs_b;

   alu_state_t            state;
   logic [CNT_W-1:0]      counter;
   logic [2:0]            m_op;
   logic [XLEN-1:0]       m_hi;
   logic [XLEN-1:0]       m_lo;
   logic [XLEN-1:0]       m_opnd;
   logic                  m_neg_a;
   logic                  m_neg_b;
   logic                  m_div_zero;

   logic [XLEN:0]         mul_sum;
   logic [XLEN:0]         div_shift;
   logic [XLEN:0]         div_diff;
   logic [2*XLEN-1:0]     prod;
   logic [2*XLEN-1:0]     prod_fix;
   logic [XLEN-1:0]       quo_fix;
   logic [XLEN-1:0]       rem_fix;
   logic [XLEN-1:0]       fix_result;

   alu_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
      .alu_op   (ALUOp),
      .op5      (op5),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .funct7_0 (funct7_0),
      .alu_ctrl (alu_ctrl)
   );

   assign shamt    = src_b[SHW-1:0];
   assign in_ready = (state == ST_IDLE);
   assign busy     = ENABLE_M && (state != ST_IDLE);
   assign zero     = (result == '0);
   assign accept   = in_valid && in_ready && !flush;
   assign start_m  = accept && ENABLE_M && is_m_code(alu_ctrl);

   always_comb begin
      base_result = '0;
      case (alu_ctrl)
         ALU_ADD:  base_result = src_a + src_b;
         ALU_SUB:  base_result = src_a - src_b;
         ALU_AND:  base_result = src_a & src_b;
         ALU_OR:   base_result = src_a | src_b;
         ALU_XOR:  base_result = src_a ^ src_b;
         ALU_SLTU: base_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         ALU_SLT:  base_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLL:  base_result = src_a << shamt;
         ALU_SRL:  base_result = src_a >> shamt;
         ALU_SRA:  base_result = $unsigned($signed(src_a) >>> shamt);
         default:  base_result = '0;
      endcase
   end

   // Iterations run on magnitudes; signs are remembered for the FIX correction
   always_comb begin
      in_f3    = alu_ctrl[2:0];
      a_signed = (in_f3 != M_MULHU) && (in_f3 != M_DIVU) && (in_f3 != M_REMU);
      b_signed = a_signed && (in_f3 != M_MULHSU);
      neg_a_in = a_signed && src_a[XLEN-1];
      neg_b_in = b_signed && src_b[XLEN-1];
      abs_a    = neg_a_in ? (~src_a + 1'b1) : src_a;
      abs_b    = neg_b_in ? (~src_b + 1'b1) : src_b;
   end

   always_comb begin
      mul_sum   = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_opnd} : '0);
      div_shift = {m_hi, m_lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, m_opnd};
   end

   // A zero divisor leaves an all-ones magnitude quotient, which signed DIV must not negate
   always_comb begin
      prod       = {m_hi, m_lo};
      prod_fix   = (m_neg_a ^ m_neg_b) ? (~prod + 1'b1) : prod;
      quo_fix    = (m_neg_a ^ m_neg_b) ? (~m_lo + 1'b1) : m_lo;
      rem_fix    = m_neg_a ? (~m_hi + 1'b1) : m_hi;
      fix_result = '0;
      case (m_op)
         M_MUL:                   fix_result = prod_fix[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:           fix_result = m_div_zero ? '1 : quo_fix;
         default:                 fix_result = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         counter    <= '0;
         result     <= '0;
         out_valid  <= 1'b0;
         m_op       <= '0;
         m_hi       <= '0;
         m_lo       <= '0;
         m_opnd     <= '0;
         m_neg_a    <= 1'b0;
         m_neg_b    <= 1'b0;
         m_div_zero <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            state   <= ST_IDLE;
            counter <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_m) begin
                     m_op       <= in_f3;
                     m_hi       <= '0;
                     m_lo       <= in_f3[2] ? abs_a : abs_b;
                     m_opnd     <= in_f3[2] ? abs_b : abs_a;
                     m_neg_a    <= neg_a_in;
                     m_neg_b    <= neg_b_in;
                     m_div_zero <= (src_b == '0);
                     counter    <= CNT_W'(XLEN-1);
                     state      <= ST_RUN;
                  end else if (accept) begin
                     result    <= base_result;
                     out_valid <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (m_op[2]) begin
                     if (!div_diff[XLEN]) begin
                        m_hi <= div_diff[XLEN-1:0];
                        m_lo <= {m_lo[XLEN-2:0], 1'b1};
                     end else begin
                        m_hi <= div_shift[XLEN-1:0];
                        m_lo <= {m_lo[XLEN-2:0], 1'b0};
                     end
                  end else begin
                     m_hi <= mul_sum[XLEN:1];
                     m_lo <= {mul_sum[0], m_lo[XLEN-1:1]};
                  end
                  if (counter == '0) begin
                     state <= ST_FIX;
                  end else begin
                     counter <= counter - CNT_W'(1);
                  end
               end
               ST_FIX: begin
                  result    <= fix_result;
                  out_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit at XLEN=32 with the M extension enabled.
module tb_alu_exec_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ALUOp;
   logic        op5;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        funct7_0;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int          checks;
   int          failures;
   logic        last_valid;
   logic [31:0] last_done;
   string       sb_tag[$];
   logic [31:0] sb_val[$];

   alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUOp     (ALUOp),
      .op5       (op5),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .funct7_0  (funct7_0),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 ns later, and retire any completion against the scoreboard
   task automatic tick();
      string tag;
      logic [31:0] exp;
      @(posedge clk);
      #1;
      last_valid = out_valid;
      if (out_valid) begin
         if (sb_val.size() == 0) begin
            checkOutput("spurious_out_valid", {63'd0, out_valid}, 64'd0);
         end else begin
            tag = sb_tag.pop_front();
            exp = sb_val.pop_front();
            checkOutput(tag, {32'd0, result}, {32'd0, exp});
            last_done = exp;
         end
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic p5, input logic [2:0] f3,
                                input logic f75, input logic f70, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input string tag,
                                input bit push);
      ALUOp    = op;
      op5      = p5;
      funct3   = f3;
      funct7_5 = f75;
      funct7_0 = f70;
      src_a    = a;
      src_b    = b;
      in_valid = 1'b1;
      if (push) begin
         sb_tag.push_back(tag);
         sb_val.push_back(exp);
      end
   endtask

   task automatic singleOp(input logic [1:0] op, input logic p5, input logic [2:0] f3,
                           input logic f75, input logic f70, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input string tag);
      applyStimulus(op, p5, f3, f75, f70, a, b, exp, tag, 1'b1);
      tick();
      checkOutput({tag, "_valid"}, {63'd0, last_valid}, 64'd1);
   endtask

   // Operands are scrambled after accept to show they were latched
   task automatic multiOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
      int n;
      applyStimulus(2'b10, 1'b1, f3, 1'b0, 1'b1, a, b, exp, tag, 1'b1);
      tick();
      n = 1;
      in_valid = 1'b0;
      src_a    = 32'hDEAD_BEEF;
      src_b    = 32'h0BAD_F00D;
      while (!last_valid && n < 60) begin
         checkOutput({tag, "_busy"}, {63'd0, busy}, 64'd1);
         checkOutput({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
         tick();
         n++;
      end
      checkOutput({tag, "_latency"}, 64'(n), 64'd34);
      checkOutput({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
      checkOutput({tag, "_ready_done"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      int n;
      checks    = 0;
      failures  = 0;
      last_valid = 1'b0;
      last_done = 32'd0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      ALUOp     = 2'b00;
      op5       = 1'b0;
      funct3    = 3'b000;
      funct7_5  = 1'b0;
      funct7_0  = 1'b0;
      src_a     = 32'd0;
      src_b     = 32'd0;

      #3;
      checkOutput("reset_result", {32'd0, result}, 64'd0);
      checkOutput("reset_zero", {63'd0, zero}, 64'd1);
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      $display("[TB] single-cycle operations");
      singleOp(2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 32'd7, 32'd5, 32'd12, "add_7_5");
      checkOutput("add_zero_flag", {63'd0, zero}, 64'd0);
      singleOp(2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub_5_7");
      singleOp(2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
      singleOp(2'b10, 1'b1, 3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1, "sltu");
      singleOp(2'b10, 1'b1, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
      singleOp(2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 32'd1, 32'h0000_003F, 32'h8000_0000, "sll_mask");
      singleOp(2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt_neg");
      singleOp(2'b10, 1'b1, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
      singleOp(2'b10, 1'b1, 3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, "or");
      singleOp(2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
      singleOp(2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 32'd10, 32'h0000_0400, 32'h0000_040A, "addi_imm10");
      singleOp(2'b10, 1'b0, 3'b000, 1'b0, 1'b1, 32'd1, 32'd1, 32'd2, "addi_f70");
      singleOp(2'b00, 1'b1, 3'b100, 1'b0, 1'b1, 32'd2, 32'd2, 32'd4, "aluop00_add");
      singleOp(2'b11, 1'b1, 3'b111, 1'b1, 1'b0, 32'd3, 32'd4, 32'd7, "aluop11_add");
      singleOp(2'b01, 1'b0, 3'b000, 1'b0, 1'b0, 32'h30, 32'h30, 32'd0, "aluop01_sub");
      checkOutput("sub_zero_flag", {63'd0, zero}, 64'd1);

      $display("[TB] multi-cycle operations");
      multiOp(3'b001, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulh");
      multiOp(3'b011, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu");
      multiOp(3'b000, 32'hFFFF_FFFD, 32'd6, 32'hFFFF_FFEE, "mul_neg");
      multiOp(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
      multiOp(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      multiOp(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      multiOp(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
      multiOp(3'b110, 32'd5, 32'd0, 32'd5, "rem_by0");
      multiOp(3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_neg_by0");
      multiOp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      multiOp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
      multiOp(3'b111, 32'd17, 32'd5, 32'd2, "remu");
      multiOp(3'b101, 32'd100, 32'd7, 32'd14, "divu");

      $display("[TB] flush during divide");
      applyStimulus(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'd1000, 32'd3, 32'd0, "flushed_div", 1'b0);
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      checkOutput("flush_busy", {63'd0, busy}, 64'd0);
      checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("flush_result_hold", {32'd0, result}, {32'd0, last_done});
      applyStimulus(2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd18, "blocked_add", 1'b0);
      tick();
      checkOutput("flush_blocks_accept", {63'd0, last_valid}, 64'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      repeat (40) tick();
      checkOutput("flush_result_still", {32'd0, result}, {32'd0, last_done});
      singleOp(2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 32'd20, 32'd22, 32'd42, "add_after_flush");

      $display("[TB] back-to-back divide then add");
      applyStimulus(2'b10, 1'b1, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "b2b_div", 1'b1);
      tick();
      applyStimulus(2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 32'h100, 32'h23, 32'h123, "b2b_add", 1'b1);
      n = 1;
      while (!last_valid && n < 60) begin
         tick();
         n++;
      end
      checkOutput("b2b_div_latency", 64'(n), 64'd34);
      checkOutput("b2b_ready_with_valid", {63'd0, in_ready}, 64'd1);
      tick();
      checkOutput("b2b_add_valid", {63'd0, last_valid}, 64'd1);
      in_valid = 1'b0;
      tick();
      checkOutput("b2b_no_duplicate", {63'd0, last_valid}, 64'd0);

      $display("[TB] reset during divide");
      applyStimulus(2'b10, 1'b1, 3'b101, 1'b0, 1'b1, 32'd77, 32'd5, 32'd0, "reset_div", 1'b0);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_result", {32'd0, result}, 64'd0);
      checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
      tick();
      checkOutput("midrst_next_result", {32'd0, result}, 64'd0);
      checkOutput("midrst_next_zero", {63'd0, zero}, 64'd1);
      checkOutput("midrst_next_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("midrst_next_busy", {63'd0, busy}, 64'd0);
      checkOutput("midrst_next_in_ready", {63'd0, in_ready}, 64'd1);
      rst_n = 1'b1;
      repeat (40) tick();
      checkOutput("post_reset_result", {32'd0, result}, 64'd0);

      checkOutput("scoreboard_drained", 64'(sb_val.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
